haze_frame_controller: RTL and testbench

- Frame-level sequencer for the two-pass dehaze pipeline.
- Pass 1 streams the stored frame through atmospheric light estimation (ALE). The controller then waits for the ALE pipeline to drain and for the ALE done flag, and latches A and 1/A (Q0.16).
- Pass 2 re-streams the frame into the dehaze/recovery datapath while holding the latched A values stable.
- Sits between the frame-buffer read port, the ALE block and the recovery datapath.

---
 rtl/haze_frame_controller.sv | 145 ++++++++++++++
 tb/tb_haze_frame_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/haze_frame_controller.sv
// haze_frame_controller: two-pass frame sequencer feeding ALE then the recovery datapath
module haze_frame_controller #(
  parameter int IMG_W   = 512,
  parameter int IMG_H   = 512,
  parameter int ADDR_W  = 18,
  parameter int RD_LAT  = 1,
  parameter int ALE_LAT = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              ale_rst,
  output logic              ale_valid,
  output logic              dhz_valid,
  input  logic              ale_done,
  input  logic [7:0]        a_r_in,
  input  logic [7:0]        a_g_in,
  input  logic [7:0]        a_b_in,
  input  logic [15:0]       inv_a_r_in,
  input  logic [15:0]       inv_a_g_in,
  input  logic [15:0]       inv_a_b_in,
  output logic [7:0]        a_r,
  output logic [7:0]        a_g,
  output logic [7:0]        a_b,
  output logic [15:0]       inv_a_r,
  output logic [15:0]       inv_a_g,
  output logic [15:0]       inv_a_b,
  output logic              busy,
  output logic              pass_id,
  output logic              frame_done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, CLR, PASS1, P1_FLUSH, LATCH, PASS2, P2_FLUSH, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT + RD_LAT + ALE_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [CW-1:0]     FLUSH1 = CW'(RD_LAT + ALE_LAT - 1);
  localparam logic [CW-1:0]     TMO    = CW'(RD_LAT + ALE_LAT - 1 + TIMEOUT);
  localparam logic [CW-1:0]     FLUSH2 = CW'(RD_LAT - 1);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                lat_en;
  logic [RD_LAT-1:0]   sr_q;
  logic [RD_LAT:0]     sr_ext;
  logic [7:0]          a_r_q, a_g_q, a_b_q;
  logic [15:0]         inv_r_q, inv_g_q, inv_b_q;
  assign sr_ext     = {sr_q, rd_en};
  assign busy       = state_q != IDLE;
  assign pass_id    = state_q inside {PASS2, P2_FLUSH, DONE};
  assign ale_valid  = sr_q[RD_LAT-1] & ~pass_id;
  assign dhz_valid  = sr_q[RD_LAT-1] & pass_id;
  assign rd_addr    = addr_q;
  assign err        = err_q;
  assign a_r        = a_r_q;
  assign a_g        = a_g_q;
  assign a_b        = a_b_q;
  assign inv_a_r    = inv_r_q;
  assign inv_a_g    = inv_g_q;
  assign inv_a_b    = inv_b_q;
  // next-state, read issue and flush/timeout decisions
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    err_d      = err_q;
    cnt_d      = (state_q inside {P1_FLUSH, P2_FLUSH}) ? (&cnt_q ? cnt_q : cnt_q + 1'b1) : '0;
    lat_en     = 1'b0;
    rd_en      = 1'b0;
    ale_rst    = ~rst_n;
    frame_done = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CLR;
        err_d   = 1'b0;
      end
      CLR: begin
        ale_rst = 1'b1;
        addr_d  = '0;
        state_d = PASS1;
      end
      PASS1, PASS2: begin
        rd_en = ~stall;
        if (rd_en) begin
          addr_d = (addr_q == LAST) ? '0 : addr_q + 1'b1;
          if (addr_q == LAST) state_d = (state_q == PASS1) ? P1_FLUSH : P2_FLUSH;
        end
      end
      P1_FLUSH: if (cnt_q >= FLUSH1) begin
        if (ale_done) state_d = LATCH;
        else if (cnt_q >= TMO) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      LATCH: begin
        lat_en  = 1'b1;
        state_d = PASS2;
      end
      P2_FLUSH: if (cnt_q == FLUSH2) state_d = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // control state, address, counter, sticky error and read-valid delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sr_q    <= sr_ext[RD_LAT-1:0];
    end
  end
  // atmospheric light and its reciprocal, captured once per frame and held through pass 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r_q   <= '0;
      a_g_q   <= '0;
      a_b_q   <= '0;
      inv_r_q <= '0;
      inv_g_q <= '0;
      inv_b_q <= '0;
    end else if (lat_en) begin
      a_r_q   <= a_r_in;
      a_g_q   <= a_g_in;
      a_b_q   <= a_b_in;
      inv_r_q <= inv_a_r_in;
      inv_g_q <= inv_a_g_in;
      inv_b_q <= inv_a_b_in;
    end
  end
endmodule

// File: tb/tb_haze_frame_controller.sv
// tb_haze_frame_controller: cycle-exact frame schedule model vs. the controller
module tb_haze_frame_controller;
  localparam int IW = 4, IH = 2, AW = 4, RDL = 1, ALEL = 2, TMO = 16;
  localparam int N = IW * IH, W = RDL + ALEL, LMAX = 120;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, stall = 1'b0, ale_done = 1'b0;
  logic [AW-1:0] rd_addr;
  logic rd_en, ale_rst, ale_valid, dhz_valid, busy, pass_id, frame_done, err;
  logic [7:0] a_r_in = '0, a_g_in = '0, a_b_in = '0, a_r, a_g, a_b;
  logic [15:0] inv_a_r_in = '0, inv_a_g_in = '0, inv_a_b_in = '0, inv_a_r, inv_a_g, inv_a_b;
  int checks = 0, errors = 0;
  bit stall_p [LMAX], start_p [LMAX];
  int done_cyc;
  logic [7:0]  in_a [LMAX][3], e_a [LMAX][3], h_a [3];
  logic [15:0] in_i [LMAX][3], e_i [LMAX][3], h_i [3];
  bit e_rden [LMAX], e_av [LMAX], e_dv [LMAX], e_busy [LMAX], e_pid [LMAX], e_fd [LMAX], e_err [LMAX], e_arst [LMAX];
  int e_addr [LMAX];
  bit h_err = 1'b0;

  haze_frame_controller #(.IMG_W(IW), .IMG_H(IH), .ADDR_W(AW), .RD_LAT(RDL), .ALE_LAT(ALEL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .rd_addr(rd_addr), .rd_en(rd_en),
    .ale_rst(ale_rst), .ale_valid(ale_valid), .dhz_valid(dhz_valid), .ale_done(ale_done),
    .a_r_in(a_r_in), .a_g_in(a_g_in), .a_b_in(a_b_in),
    .inv_a_r_in(inv_a_r_in), .inv_a_g_in(inv_a_g_in), .inv_a_b_in(inv_a_b_in),
    .a_r(a_r), .a_g(a_g), .a_b(a_b), .inv_a_r(inv_a_r), .inv_a_g(inv_a_g), .inv_a_b(inv_a_b),
    .busy(busy), .pass_id(pass_id), .frame_done(frame_done), .err(err));

  always #5 clk = ~clk;

  task automatic prep(input int dc, input int stall_pct);
    done_cyc = dc;
    for (int k = 0; k < LMAX; k++) begin
      stall_p[k] = (k < 50) && ($urandom_range(0, 99) < stall_pct);
      start_p[k] = (k == 0);
      for (int c = 0; c < 3; c++) begin
        in_a[k][c] = 8'($urandom);
        in_i[k][c] = 16'($urandom);
      end
    end
  endtask

  // Expected per-cycle outputs, cycle 0 being the cycle start is high in IDLE.
  task automatic build_model(output int endc);
    int t, reads, last, c0, latch, dn;
    for (int k = 0; k < LMAX; k++) begin
      e_rden[k] = 0; e_addr[k] = 0; e_av[k] = 0; e_dv[k] = 0; e_busy[k] = 0;
      e_pid[k] = 0; e_fd[k] = 0; e_err[k] = (k == 0) ? h_err : 1'b0; e_arst[k] = (k == 1);
      for (int c = 0; c < 3; c++) begin
        e_a[k][c] = h_a[c];
        e_i[k][c] = h_i[c];
      end
    end
    e_busy[1] = 1;
    t = 2; reads = 0;
    while (reads < N) begin
      e_busy[t] = 1; e_addr[t] = reads;
      if (!stall_p[t]) begin e_rden[t] = 1; e_av[t+RDL] = 1; reads++; end
      t++;
    end
    last = t - 1; c0 = last + W; latch = -1;
    for (int d = last + 1; d <= c0 + TMO && latch < 0; d++) begin
      e_busy[d] = 1;
      if (d >= c0 && d >= done_cyc) latch = d + 1;
    end
    if (latch < 0) begin
      endc = c0 + TMO + 1;
      for (int k = endc; k < LMAX; k++) e_err[k] = 1;
      return;
    end
    e_busy[latch] = 1;
    for (int k = latch + 1; k < LMAX; k++)
      for (int c = 0; c < 3; c++) begin
        e_a[k][c] = in_a[latch][c];
        e_i[k][c] = in_i[latch][c];
      end
    t = latch + 1; reads = 0;
    while (reads < N) begin
      e_busy[t] = 1; e_pid[t] = 1; e_addr[t] = reads;
      if (!stall_p[t]) begin e_rden[t] = 1; e_dv[t+RDL] = 1; reads++; end
      t++;
    end
    last = t - 1; dn = last + RDL + 1;
    for (int k = last + 1; k <= dn; k++) begin e_busy[k] = 1; e_pid[k] = 1; end
    e_fd[dn] = 1;
    endc = dn + 1;
  endtask

  task automatic run_frame(input string nm, output int fdc, output int nav, output int nfd);
    int endc;
    logic [11:0] got, exp;
    logic [71:0] gl, el;
    build_model(endc);
    fdc = -1; nav = 0; nfd = 0;
    for (int k = 0; k <= endc + 2; k++) begin
      start = start_p[k]; stall = stall_p[k]; ale_done = (k >= done_cyc);
      a_r_in = in_a[k][0]; a_g_in = in_a[k][1]; a_b_in = in_a[k][2];
      inv_a_r_in = in_i[k][0]; inv_a_g_in = in_i[k][1]; inv_a_b_in = in_i[k][2];
      @(negedge clk);
      got = {rd_en, rd_addr, ale_valid, dhz_valid, busy, pass_id, frame_done, err, ale_rst};
      exp = {e_rden[k], AW'(e_addr[k]), e_av[k], e_dv[k], e_busy[k], e_pid[k], e_fd[k], e_err[k], e_arst[k]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s ctl cyc %0d got %h exp %h (rd_en,addr,av,dv,busy,pass,fd,err,arst)", nm, k, got, exp);
      end
      gl = {a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b};
      el = {e_a[k][0], e_a[k][1], e_a[k][2], e_i[k][0], e_i[k][1], e_i[k][2]};
      checks++;
      if (gl !== el) begin
        errors++;
        $display("FAIL %s latched cyc %0d got %h exp %h", nm, k, gl, el);
      end
      if (frame_done === 1'b1) begin nfd++; if (fdc < 0) fdc = k; end
      if (ale_valid === 1'b1) nav++;
      @(posedge clk); #1;
    end
    start = 0; stall = 0; ale_done = 0;
    h_err = e_err[endc];
    for (int c = 0; c < 3; c++) begin h_a[c] = e_a[endc][c]; h_i[c] = e_i[endc][c]; end
  endtask

  task automatic check_reset_outputs(input string nm);
    logic [11:0] got;
    logic [71:0] gl;
    got = {rd_en, rd_addr, ale_valid, dhz_valid, busy, pass_id, frame_done, err, ale_rst};
    gl = {a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b};
    checks++;
    if (got !== 12'h001) begin errors++; $display("FAIL %s ctl got %h exp 001", nm, got); end
    checks++;
    if (gl !== 72'h0) begin errors++; $display("FAIL %s latched got %h exp 0", nm, gl); end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin h_a[c] = '0; h_i[c] = '0; end
    h_err = 0;
  endtask

  task automatic test_nominal;
    int fdc, nav, nfd;
    prep(11, 0);
    for (int k = 0; k < LMAX; k++) begin
      in_a[k][0] = (k <= 13) ? 8'd200 : 8'd10;
      in_i[k][0] = (k <= 13) ? 16'd328 : 16'd6554;
    end
    run_frame("nominal", fdc, nav, nfd);
    checks++;
    if (fdc != 23) begin errors++; $display("FAIL nominal frame_done cycle got %0d exp 23", fdc); end
    checks++;
    if (nav != 8) begin errors++; $display("FAIL nominal ale_valid pulses got %0d exp 8", nav); end
    checks++;
    if (a_r !== 8'd200 || inv_a_r !== 16'd328) begin
      errors++; $display("FAIL latch_hold after done got %0d/%0d exp 200/328", a_r, inv_a_r);
    end
  endtask

  task automatic test_stall;
    int fdc, nav, nfd;
    prep(13, 0);
    stall_p[4] = 1; stall_p[5] = 1;
    run_frame("stall", fdc, nav, nfd);
    checks++;
    if (fdc != 25) begin errors++; $display("FAIL stall frame_done cycle got %0d exp 25", fdc); end
    checks++;
    if (nav != 8) begin errors++; $display("FAIL stall ale_valid pulses got %0d exp 8", nav); end
  endtask

  task automatic test_timeout;
    int fdc, nav, nfd;
    prep(1000, 0);
    run_frame("timeout", fdc, nav, nfd);
    checks++;
    if (nfd != 0) begin errors++; $display("FAIL timeout frame_done pulses got %0d exp 0", nfd); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL timeout err got %b exp 1", err); end
    prep(11, 0);
    run_frame("err_clear", fdc, nav, nfd);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear err got %b exp 0", err); end
  endtask

  task automatic test_start_busy;
    int fdc, nav, nfd;
    prep(11, 0);
    start_p[16] = 1; start_p[20] = 1;
    run_frame("start_busy", fdc, nav, nfd);
    checks++;
    if (nfd != 1) begin errors++; $display("FAIL start_busy frame_done pulses got %0d exp 1", nfd); end
  endtask

  task automatic test_random;
    int fdc, nav, nfd;
    for (int i = 0; i < 6; i++) begin
      prep($urandom_range(0, 40), 25);
      run_frame("random", fdc, nav, nfd);
    end
  endtask

  task automatic test_async_reset;
    int fdc, nav, nfd;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (busy !== 1'b1 || rd_en !== 1'b1) begin
      errors++; $display("FAIL async_pre busy/rd_en got %b%b exp 11", busy, rd_en);
    end
    rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    for (int c = 0; c < 3; c++) begin h_a[c] = '0; h_i[c] = '0; end
    h_err = 0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    prep(11, 10);
    run_frame("post_reset", fdc, nav, nfd);
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin h_a[c] = '0; h_i[c] = '0; end
    test_reset;
    test_nominal;
    test_stall;
    test_timeout;
    test_start_busy;
    test_random;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
